// File: rtl/down_counter_tff.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_tff (with helper down_counter_tff_tflop)
// Description : 4-bit fully synchronous binary down counter built from four
//               T flip-flops on a common clock. Counts 15..0 and wraps.
//               State bits are exposed individually as Q4 (MSB) .. Q1 (LSB).
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Single T flip-flop with synchronous active-high reset to RESET_VALUE.
// ----------------------------------------------------------------------------
module down_counter_tff_tflop #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic r_q;

    // Reset wins over toggling; otherwise toggle when t is high, hold when low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// ----------------------------------------------------------------------------
// Counter top level: four T flops, each toggling when every lower bit is 0,
// which is exactly the borrow chain of a binary decrement.
// ----------------------------------------------------------------------------
module down_counter_tff #(
    parameter logic [3:0] RESET_VALUE = 4'b0000
) (
    input  logic clk,
    input  logic rst,
    output logic Q4,
    output logic Q3,
    output logic Q2,
    output logic Q1
);

    localparam int c_WIDTH = 4;

    logic [c_WIDTH-1:0] w_q;
    logic [c_WIDTH-1:0] w_t;

    // The LSB always toggles.
    assign w_t[0] = 1'b1;

    // Higher bits toggle only when all lower bits are zero (borrow ripples
    // through). Each term depends on flop outputs only, so there is no
    // combinational path from any input to the outputs.
    generate
        for (genvar i = 1; i < c_WIDTH; i++) begin : g_toggle
            assign w_t[i] = ~|w_q[i-1:0];
        end
    endgenerate

    // One flop per state bit, all on the same clock edge.
    generate
        for (genvar i = 0; i < c_WIDTH; i++) begin : g_tff
            down_counter_tff_tflop #(
                .RESET_VALUE (RESET_VALUE[i])
            ) u_tff (
                .clk (clk),
                .rst (rst),
                .t   (w_t[i]),
                .q   (w_q[i])
            );
        end
    endgenerate

    assign Q4 = w_q[3];
    assign Q3 = w_q[2];
    assign Q2 = w_q[1];
    assign Q1 = w_q[0];

endmodule

`default_nettype wire

// File: tb/tb_down_counter_tff.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter_tff
// Description : Scoreboard bench for down_counter_tff. Two instances: default
//               reset value (A) and RESET_VALUE = 4'b0101 (B). The driver
//               pushes hand-computed expected states after each rising edge;
//               a monitor pops and compares on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_tff;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic a4, a3, a2, a1;
    logic b4, b3, b2, b1;

    logic [3:0] q_exp_a[$];
    logic [3:0] q_exp_b[$];

    int n_cmp;
    int n_err;

    down_counter_tff u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .Q4  (a4),
        .Q3  (a3),
        .Q2  (a2),
        .Q1  (a1)
    );

    down_counter_tff #(
        .RESET_VALUE (4'b0101)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .Q4  (b4),
        .Q3  (b3),
        .Q2  (b2),
        .Q1  (b1)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every falling edge, compare the state produced by the
    // preceding rising edge against whatever the driver queued.
    always @(negedge clk) begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        if (q_exp_a.size() > 0) begin
            exp_v = q_exp_a.pop_front();
            act_v = {a4, a3, a2, a1};
            n_cmp = n_cmp + 1;
            if (act_v !== exp_v) begin
                n_err = n_err + 1;
                $display("FAIL dut_a_state t=%0t actual=%b required=%b", $time, act_v, exp_v);
            end
        end
        if (q_exp_b.size() > 0) begin
            exp_v = q_exp_b.pop_front();
            act_v = {b4, b3, b2, b1};
            n_cmp = n_cmp + 1;
            if (act_v !== exp_v) begin
                n_err = n_err + 1;
                $display("FAIL dut_b_state t=%0t actual=%b required=%b", $time, act_v, exp_v);
            end
        end
    end

    // One rising edge: apply reset levels, then queue what each counter
    // must show after the edge. Returns at the following falling edge.
    task automatic edge_step(input logic ra, input logic [3:0] ea,
                             input logic rb, input logic [3:0] eb);
        rst_a = ra;
        rst_b = rb;
        @(posedge clk);
        q_exp_a.push_back(ea);
        q_exp_b.push_back(eb);
        @(negedge clk);
    endtask

    // Same as edge_step for A (rst low), but with a glitch on rst_a that
    // rises after the edge and falls before the next one.
    task automatic edge_with_pulse(input logic [3:0] ea, input logic [3:0] eb);
        rst_a = 1'b0;
        rst_b = 1'b1;
        @(posedge clk);
        q_exp_a.push_back(ea);
        q_exp_b.push_back(eb);
        #1 rst_a = 1'b1;
        #2 rst_a = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Power-up reset: edges at 5 and 15 ns in reset, release at 20 ns.
        edge_step(1'b1, 4'b0000, 1'b1, 4'b0101);
        edge_step(1'b1, 4'b0000, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1111, 1'b1, 4'b0101);   // 25 ns
        edge_step(1'b0, 4'b1110, 1'b1, 4'b0101);   // 35 ns
        edge_step(1'b0, 4'b1101, 1'b1, 4'b0101);   // 45 ns

        // Full cycle from a fresh reset: 1111 down to 0000, then wrap.
        edge_step(1'b1, 4'b0000, 1'b1, 4'b0101);
        for (int i = 0; i < 16; i++) begin
            edge_step(1'b0, 4'(15 - i), 1'b1, 4'b0101);
        end
        edge_step(1'b0, 4'b1111, 1'b1, 4'b0101);

        // Run to 1010, then a single reset edge, then resume.
        edge_step(1'b0, 4'b1110, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1101, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1100, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1011, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1010, 1'b1, 4'b0101);
        edge_step(1'b1, 4'b0000, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1111, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1110, 1'b1, 4'b0101);

        // Held reset for ten edges.
        for (int i = 0; i < 10; i++) begin
            edge_step(1'b1, 4'b0000, 1'b1, 4'b0101);
        end
        edge_step(1'b0, 4'b1111, 1'b1, 4'b0101);

        // Reset pulses confined between edges must be ignored.
        edge_with_pulse(4'b1110, 4'b0101);
        edge_with_pulse(4'b1101, 4'b0101);
        edge_step(1'b0, 4'b1100, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1011, 1'b1, 4'b0101);

        // Non-default reset value: B counts down from 0101 and wraps.
        edge_step(1'b1, 4'b0000, 1'b1, 4'b0101);
        edge_step(1'b1, 4'b0000, 1'b0, 4'b0100);
        edge_step(1'b1, 4'b0000, 1'b0, 4'b0011);
        edge_step(1'b1, 4'b0000, 1'b0, 4'b0010);
        edge_step(1'b1, 4'b0000, 1'b0, 4'b0001);
        edge_step(1'b1, 4'b0000, 1'b0, 4'b0000);
        edge_step(1'b1, 4'b0000, 1'b0, 4'b1111);
        edge_step(1'b1, 4'b0000, 1'b0, 4'b1110);
        edge_step(1'b0, 4'b1111, 1'b1, 4'b0101);
        edge_step(1'b0, 4'b1110, 1'b0, 4'b0100);

        // Let the monitor drain; anything left over counts as a miss.
        @(negedge clk);
        if (q_exp_a.size() != 0 || q_exp_b.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain actual=%0d/%0d pending required=0/0",
                     q_exp_a.size(), q_exp_b.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/down_counter_tff.md
Name: down_counter_tff

Overview:
- 4-bit synchronous binary down counter built from four T flip-flops sharing one clock.
- Decrements by one on every rising clock edge while not in reset, and wraps from 0 to 15.
- Serves as a free-running count/sequence source. Its state bits are exposed individually as Q4 (MSB) through Q1 (LSB).

Parameters:
- RESET_VALUE, 4'b0000, state loaded on synchronous reset; Q4 is bit 3 and Q1 is bit 0.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high; loads RESET_VALUE.
- Q4  output  1  counter bit 3 (MSB).
- Q3  output  1  counter bit 2.
- Q2  output  1  counter bit 1.
- Q1  output  1  counter bit 0 (LSB).

Behaviour:
- One clock; reset is synchronous and active-high.
- State is {Q4,Q3,Q2,Q1}, held in four T flip-flops. Each flop toggles on a rising clk edge when its T input is 1 and holds when T is 0.
- Structure: a separate T flip-flop submodule with inputs clk, rst, t and output q, instantiated four times. The flop's synchronous reset value comes from RESET_VALUE.
- Toggle equations for down counting (a bit toggles when all lower bits are 0):
  - T1 = 1
  - T2 = ~Q1
  - T3 = ~Q1 & ~Q2
  - T4 = ~Q1 & ~Q2 & ~Q3
- This is a fully synchronous design, not a ripple counter: all four flops are clocked by clk, so all output bits change together on the same edge.
- Reset:
  - On a rising edge with rst=1, state becomes RESET_VALUE (default 0000) regardless of current state.
  - Reset has priority over counting.
  - While rst stays high, the state holds at RESET_VALUE.
- Counting:
  - On a rising edge with rst=0, next state = (state − 1) mod 16.
  - Latency is one edge: the first decrement appears on the first rising edge at which rst is sampled low.
- Wrap-around: 0000 → 1111, then the count continues 1110, 1101, and so on. The period is 16 clocks.
- Reset mid-count: asserting rst at any state forces RESET_VALUE at the next edge. Counting resumes from RESET_VALUE on the first edge with rst low.
- No enable, load, or direction control; the counter counts continuously whenever out of reset.
- Outputs are direct flop outputs (registered, no combinational path from inputs).
- The state before the first reset edge is unspecified (X in simulation). The bench must apply reset before checking outputs.
- rst changes between clock edges have no effect until the next rising edge; there is no asynchronous clear.

Test Plan:
- Power-up reset: clk period 10 ns, rst=1 for the first two rising edges (5 ns, 15 ns), released at 20 ns → {Q4..Q1}=0000 after the 5 ns edge and still 0000 at 15 ns. At 25 ns it reads 1111, at 35 ns 1110, at 45 ns 1101.
- Full cycle: from reset release, sample 16 consecutive edges → sequence 1111, 1110, …, 0001, 0000 with no skipped or repeated values; the 17th edge yields 1111 again.
- Reset mid-count: drop rst, run until state=1010, assert rst for one edge → 0000 on that edge. Deassert → next edge 1111.
- Held reset: keep rst=1 for 10 edges → state stays 0000 on every edge with no toggling of any bit.
- Synchronous reset check: pulse rst high between edges only (rise after one edge, fall before the next) → no change in count; the sequence continues uninterrupted.
- Parameter check: instantiate with RESET_VALUE=4'b0101, reset, then release → 0101, then 0100, 0011 on successive edges. Every edge's value must equal the previous value − 1 mod 16.
